logic_unit_arbiter: RTL and testbench

LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

---
 rtl/logic_unit_arbiter.sv | 139 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Four-requester round-robin front end for a small bitwise logic unit.
// One transaction in flight: IDLE grants and captures a request, EXEC
// computes the result into the output register, RESP holds it until the
// consumer takes it.
module logic_unit_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req_valid,
   output logic [3:0]         req_ready,
   input  logic [11:0]        req_op,
   input  logic [4*WIDTH-1:0] req_a,
   input  logic [4*WIDTH-1:0] req_b,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [1:0]         rsp_id,
   output logic [WIDTH-1:0]   rsp_y,
   output logic               rsp_err,
   output logic               busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       last_grant;
   logic [1:0]       cand;
   logic [1:0]       grant_idx;
   logic             grant_any;
   logic             accept;
   logic [2:0]       sel_op;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;
   logic [2:0]       cap_op;
   logic [WIDTH-1:0] cap_a;
   logic [WIDTH-1:0] cap_b;
   logic [1:0]       cap_id;
   logic [WIDTH-1:0] alu_y;
   logic             alu_err;

   // Round-robin search: first valid requester after last_grant, wrapping mod 4
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= 4; k++) begin
         cand = last_grant + 2'(k);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   // Select the winning requester's opcode and operands
   always_comb begin
      sel_op = '0;
      sel_a  = '0;
      sel_b  = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (grant_idx == 2'(i)) begin
            sel_op = req_op[3*i +: 3];
            sel_a  = req_a[WIDTH*i +: WIDTH];
            sel_b  = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   assign accept    = (state == IDLE) && grant_any;
   // Gated by rst_n so no grant is advertised while reset is held
   assign req_ready = (rst_n && accept) ? (4'b0001 << grant_idx) : '0;
   assign rsp_valid = (state == RESP);
   assign busy      = (state != IDLE);

   // Bitwise logic unit on the captured operands
   always_comb begin
      alu_y   = '0;
      alu_err = 1'b0;
      case (cap_op)
         3'b000:  alu_y = cap_a & cap_b;
         3'b001:  alu_y = cap_a | cap_b;
         3'b010:  alu_y = ~cap_a;
         3'b011:  alu_y = cap_a ^ cap_b;
         3'b100:  alu_y = ~(cap_a & cap_b);
         3'b101:  alu_y = ~(cap_a | cap_b);
         default: alu_err = 1'b1;
      endcase
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXEC;
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Request capture on transfer, result load in EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= 2'd3;
         cap_op     <= '0;
         cap_a      <= '0;
         cap_b      <= '0;
         cap_id     <= '0;
         rsp_y      <= '0;
         rsp_err    <= 1'b0;
         rsp_id     <= '0;
      end else begin
         if (accept) begin
            cap_op     <= sel_op;
            cap_a      <= sel_a;
            cap_b      <= sel_b;
            cap_id     <= grant_idx;
            last_grant <= grant_idx;
         end
         if (state == EXEC) begin
            rsp_y   <= alu_y;
            rsp_err <= alu_err;
            rsp_id  <= cap_id;
         end
      end
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: the driver pushes the expected
// response at each grant, the monitor pops and compares on every handshake.
module tb_logic_unit_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [11:0] req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_y;
   logic        rsp_err;
   logic        busy;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] y;
      logic       err;
   } rsp_t;

   rsp_t exp_q[$];
   int   vectors    = 0;
   int   miscompares = 0;
   int   cyc        = 0;

   logic_unit_arbiter #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_y     (rsp_y),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_timeout(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Monitor: every accepted response must match the head of the queue
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_rsp: got id=%0d y=%h err=%0d expected none", rsp_id, rsp_y, rsp_err);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            check("rsp_id", 32'(rsp_id), 32'(e.id));
            check("rsp_y", 32'(rsp_y), 32'(e.y));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant;
      int n = 0;
      #1;
      while (req_ready == 4'b0000 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (req_ready == 4'b0000) fail_timeout("wait_grant");
   endtask

   task automatic wait_idle;
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) fail_timeout("wait_idle");
   endtask

   task automatic push(input int id, input logic [7:0] y, input logic e);
      rsp_t r;
      r.id  = 2'(id);
      r.y   = y;
      r.err = e;
      exp_q.push_back(r);
   endtask

   task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[3*id +: 3] = op;
      req_a[8*id +: 8]  = a;
      req_b[8*id +: 8]  = b;
   endtask

   // One request from a single requester; operands are scrambled after the
   // transfer edge so a result depending on live inputs would be caught
   task automatic send(input int id, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] y, input logic e);
      set_req(id, op, a, b);
      req_valid[id] = 1'b1;
      wait_grant();
      check("grant_single", 32'(req_ready), 32'(1) << id);
      push(id, y, e);
      tick();
      req_valid[id] = 1'b0;
      set_req(id, ~op, ~a, ~b);
      wait_idle();
   endtask

   logic [7:0] rr_y [4] = '{8'h30, 8'hFC, 8'h0F, 8'hCC};

   initial begin
      int last_cyc;
      int exp_id;
      int n;
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;

      // Reset state, with requests pending so req_ready gating is visible
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      check("rst_rsp_y", 32'(rsp_y), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      req_valid = 4'h0;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);

      // Single request with latency check
      set_req(0, 3'b000, 8'hF0, 8'h3C);
      req_valid = 4'b0001;
      wait_grant();
      check("grant_first", 32'(req_ready), 32'b0001);
      push(0, 8'h30, 1'b0);
      tick();
      req_valid = 4'b0000;
      @(negedge clk);
      check("lat_exec_valid", 32'(rsp_valid), 32'd0);
      check("lat_exec_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("lat_resp_valid", 32'(rsp_valid), 32'd1);
      wait_idle();

      // Directed opcode vectors
      send(1, 3'b010, 8'h0F, 8'hAA, 8'hF0, 1'b0);
      send(2, 3'b111, 8'hFF, 8'h00, 8'h00, 1'b1);
      send(0, 3'b001, 8'hA5, 8'h5A, 8'hFF, 1'b0);
      send(1, 3'b011, 8'hCC, 8'hAA, 8'h66, 1'b0);
      send(2, 3'b100, 8'hF0, 8'h3C, 8'hCF, 1'b0);
      send(2, 3'b110, 8'h12, 8'h34, 8'h00, 1'b1);
      send(3, 3'b101, 8'h00, 8'h00, 8'hFF, 1'b0);
      send(3, 3'b100, 8'hFF, 8'hFF, 8'h00, 1'b0);

      // All four requesters held valid: grants 0,1,2,3,0,1 every 3 cycles
      for (int i = 0; i < 4; i++) set_req(i, 3'(i), 8'hF0, 8'h3C);
      req_valid = 4'hF;
      last_cyc  = 0;
      for (int k = 0; k < 6; k++) begin
         exp_id = k % 4;
         wait_grant();
         check("rr_grant", 32'(req_ready), 32'(1) << exp_id);
         push(exp_id, rr_y[exp_id], 1'b0);
         if (k > 0) check("rr_spacing", 32'(cyc - last_cyc), 32'd3);
         last_cyc = cyc;
         tick();
      end
      req_valid = 4'h0;
      wait_idle();

      // Consumer stall: response held, pending requester 3 waits for handshake
      rsp_ready = 1'b0;
      set_req(2, 3'b011, 8'h3C, 8'hFF);
      set_req(3, 3'b000, 8'hFF, 8'h81);
      req_valid = 4'b1100;
      wait_grant();
      check("stall_grant", 32'(req_ready), 32'b0100);
      push(2, 8'hC3, 1'b0);
      tick();
      req_valid = 4'b1000;
      n = 0;
      while (!rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!rsp_valid) fail_timeout("stall_rsp");
      repeat (5) begin
         @(negedge clk);
         check("stall_valid", 32'(rsp_valid), 32'd1);
         check("stall_y", 32'(rsp_y), 32'hC3);
         check("stall_id", 32'(rsp_id), 32'd2);
         check("stall_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      wait_grant();
      check("post_stall_grant", 32'(req_ready), 32'b1000);
      push(3, 8'h81, 1'b0);
      tick();
      req_valid = 4'b0000;
      wait_idle();

      // Reset during EXEC drops the transaction and restores last_grant=3
      set_req(1, 3'b000, 8'hFF, 8'hFF);
      req_valid = 4'b0010;
      wait_grant();
      check("pre_rst_grant", 32'(req_ready), 32'b0010);
      tick();
      req_valid = 4'b0000;
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      set_req(0, 3'b001, 8'h0F, 8'hF0);
      set_req(3, 3'b000, 8'hAA, 8'h55);
      req_valid = 4'b1001;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_grant();
      check("post_rst_grant", 32'(req_ready), 32'b0001);
      push(0, 8'hFF, 1'b0);
      tick();
      req_valid = 4'b0000;
      wait_idle();
      repeat (4) @(negedge clk);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
